// File: rtl/bootram_pkg.sv
// Purpose : shared types and constants for the boot RAM bus controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//   Contents: FSM state enum, lane/size constants, byte-lane one-hot decode.
package bootram_pkg;

  // Two-phase access: IDLE samples a request, ACK returns the single ready pulse.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam int LANES     = 4;
  localparam int RAM_BYTES = 8192;

  // Byte offset within a word -> write enable for the one lane that holds it.
  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bootram_ld_ptr.sv
// Purpose : byte pointer for the UART loader stream, with wrap or saturate at the top.
// Latency : pointer advances on the clock edge that accepts a byte.
// Backpressure: asserts sat when saturated so the top stops accepting bytes.
//   Ports: clk, resetn (async active-low), ld_start (restart pulse), ld_accept (byte taken),
//          ptr (byte address of the next loader write), sat (no more bytes), ld_ovf (sticky wrap).
module bootram_ld_ptr
  import bootram_pkg::*;
#(
  parameter int AW      = 11,
  parameter bit LD_WRAP = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_start,
  input  logic          ld_accept,
  output logic [AW+1:0] ptr,
  output logic          sat,
  output logic          ld_ovf
);

  localparam logic [AW+1:0] PTR_MAX = '1;

  logic [AW+1:0] ptr_q, ptr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (ld_start) begin
      // Restart wins over any byte offered in the same cycle.
      ptr_d  = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (ld_accept) begin
      if (ptr_q == PTR_MAX) begin
        if (LD_WRAP) begin
          ptr_d = '0;
          ovf_d = 1'b1;
        end else begin
          // Last byte is written, pointer parks here until the next restart.
          full_d = 1'b1;
        end
      end else begin
        ptr_d = ptr_q + (AW+2)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ptr    = ptr_q;
  assign sat    = full_q;
  assign ld_ovf = ovf_q;

endmodule

// File: rtl/bootram_bus_ctrl.sv
// Purpose : PicoRV32 native-bus slave for the 8 KB four-lane boot RAM, plus loader port and write-protect.
// Latency : CPU read/write acknowledged one cycle after acceptance; no back-to-back accepts.
// Backpressure: CPU has strict priority; loader is held off (ld_ready=0) while the CPU is active or ptr saturated.
//   Ports: clk/resetn; mem_* CPU bus; wp_en/wp_viol write protect; ld_* loader stream;
//          ram_* shared lane controls (ce/oce/reset/ad/din common, wre per lane, dout read back).
module bootram_bus_ctrl
  import bootram_pkg::*;
#(
  parameter int AW      = 11,
  parameter bit LD_WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  // CPU native memory bus
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  // Write protect
  input  logic              wp_en,
  output logic              wp_viol,
  // Loader byte stream
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_ovf,
  // RAM lanes
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic [LANES-1:0]  ram_wre,
  output logic [AW-1:0]     ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_e          state_q, state_d;
  logic [1:0]      rst_sync_q, rst_sync_d;
  logic            wp_viol_q, wp_viol_d;
  logic            run;
  logic            cpu_acc;
  logic            ld_acc;
  logic            ld_sat;
  logic [AW+1:0]   ld_ptr;

  // Only the word index inside the 8 KB window is decoded; the rest aliases.
  logic            unused_addr;
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Reset synchroniser: asserts immediately with resetn, releases two clocks later.
  // It also gates every combinational strobe so nothing reaches the RAM during reset.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run       = rst_sync_q[1];
  assign ram_reset = ~run;

  assign cpu_acc = run && (state_q == IDLE) && mem_valid;
  // Loader only uses otherwise-idle RAM cycles; a restart pulse drops the byte offered with it.
  assign ld_acc  = run && (state_q == IDLE) && !mem_valid && ld_valid && !ld_sat && !ld_start;

  always_comb begin
    state_d = IDLE;
    if (cpu_acc) state_d = ACK;
  end

  always_comb begin
    wp_viol_d = wp_viol_q;
    if (ld_start) wp_viol_d = 1'b0;
    // A violation in the same cycle as a restart is still recorded.
    if (cpu_acc && wp_en && (|mem_wstrb)) wp_viol_d = 1'b1;
  end

  // Lane strobes are driven in the accept cycle; the RAM registers them on the next edge.
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = '0;
    ram_ad  = mem_addr[AW+1:2];
    ram_din = mem_wdata;
    if (cpu_acc) begin
      ram_ce  = 1'b1;
      ram_wre = wp_en ? '0 : mem_wstrb;
    end else if (ld_acc) begin
      ram_ce  = 1'b1;
      ram_ad  = ld_ptr[AW+1:2];
      ram_din = {LANES{ld_data}};
      ram_wre = lane_onehot(ld_ptr[1:0]);
    end
  end

  assign ram_oce   = ram_ce;
  assign ld_ready  = ld_acc;
  assign mem_ready = (state_q == ACK);
  // RAM output is valid exactly in the ACK cycle; zero otherwise so the bus mux stays clean.
  assign mem_rdata = mem_ready ? ram_dout : 32'h0;
  assign wp_viol   = wp_viol_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rst_sync_q <= 2'b00;
      wp_viol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_sync_q <= rst_sync_d;
      wp_viol_q  <= wp_viol_d;
    end
  end

  bootram_ld_ptr #(
    .AW      (AW),
    .LD_WRAP (LD_WRAP)
  ) u_ld_ptr (
    .clk       (clk),
    .resetn    (resetn),
    .ld_start  (ld_start),
    .ld_accept (ld_acc),
    .ptr       (ld_ptr),
    .sat       (ld_sat),
    .ld_ovf    (ld_ovf)
  );

endmodule
